// File: rtl/prover_compute_v_gatesink_if.sv
// V-value handshake bundle between the V shift-register bank, the gate sink and the gate evaluator.
// Latency: none, this is wiring only.
// Backpressure: gates_ready flows back to the bank, and q_ack flows back from the evaluator.
// Ports: in_vals/gates_en/gates_ready (bank side), q_vals/q_valid/q_ack (consumer side),
//        count/all_empty/overflow (status).
interface prover_compute_v_gatesink_if #(
    parameter int nParallel = 1,
    parameter int F_NBITS   = 61,
    parameter int nCntBits  = 8
);
    logic [nParallel-1:0][3:0][F_NBITS-1:0] in_vals;
    logic [nParallel-1:0]                   gates_en;
    logic [nParallel-1:0]                   gates_ready;
    logic [nParallel-1:0][3:0][F_NBITS-1:0] q_vals;
    logic [nParallel-1:0]                   q_valid;
    logic [nParallel-1:0]                   q_ack;
    logic [nParallel-1:0][nCntBits-1:0]     count;
    logic                                   all_empty;
    logic                                   overflow;

    // master: bank plus consumer (drives strobes and acks).
    modport master (
        output in_vals, gates_en, q_ack,
        input  gates_ready, q_vals, q_valid, count, all_empty, overflow
    );

    // slave: the gate sink itself.
    modport slave (
        input  in_vals, gates_en, q_ack,
        output gates_ready, q_vals, q_valid, count, all_empty, overflow
    );
endinterface

// File: rtl/prover_compute_v_gatesink.sv
// Per-lane 2-entry quad FIFO that sinks V values from the bank and feeds gate evaluation.
// Latency: an accepted strobe at edge N is visible on q_valid/q_vals in cycle N+1.
// Backpressure: gates_ready = FIFO not full (registered), and a strobe into a full lane is dropped and flagged.
// Ports: clk, rstb (async active-low), restart (sync clear), vbus (slave side of the V handshake).

// Marker module: it is instantiated only when nParallel is overridden inconsistently.
module prover_compute_v_gatesink_param_error;
endmodule

module prover_compute_v_gatesink #(
    parameter int nParBits  = 0,
    parameter int nCntBits  = 8,
    parameter int F_NBITS   = 61,
    parameter int nParallel = 1 << nParBits
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            restart,
    prover_compute_v_gatesink_if.slave      vbus
);
    if (nParallel != (1 << nParBits)) begin : g_param_check
        prover_compute_v_gatesink_param_error u_param_error ();
    end

    logic [nParallel-1:0][1:0][3:0][F_NBITS-1:0] mem;
    logic [nParallel-1:0]                        rd_ptr;
    logic [nParallel-1:0]                        wr_ptr;
    logic [nParallel-1:0][1:0]                   occ;
    logic [nParallel-1:0][nCntBits-1:0]          cnt;
    logic                                        ovf;

    logic [nParallel-1:0] acc;
    logic [nParallel-1:0] pop;
    logic [nParallel-1:0] drop;

    // restart masks both sides, so a colliding strobe or ack is simply lost.
    // A full lane drops its strobe even when the head is popped in the same cycle,
    // so there is no combinational path from q_ack to the write.
    always_comb begin
        acc  = '0;
        pop  = '0;
        drop = '0;
        for (int i = 0; i < nParallel; i++) begin
            acc[i]  = vbus.gates_en[i] && (occ[i] != 2'd2) && !restart;
            drop[i] = vbus.gates_en[i] && (occ[i] == 2'd2) && !restart;
            pop[i]  = vbus.q_ack[i]    && (occ[i] != 2'd0) && !restart;
        end
    end

    // Storage is reset asynchronously so that q_vals reads 0 after reset, and restart leaves it alone.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            mem <= '0;
        end else begin
            for (int i = 0; i < nParallel; i++) begin
                if (acc[i]) begin
                    mem[i][wr_ptr[i]] <= vbus.in_vals[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (restart) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            for (int i = 0; i < nParallel; i++) begin
                if (acc[i]) begin
                    wr_ptr[i] <= ~wr_ptr[i];
                    if (cnt[i] != {nCntBits{1'b1}}) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
                if (pop[i]) begin
                    rd_ptr[i] <= ~rd_ptr[i];
                end
                // At occ==1, accept plus pop keeps occ. The freshly written tail becomes the head.
                case ({acc[i], pop[i]})
                    2'b10:   occ[i] <= occ[i] + 2'd1;
                    2'b01:   occ[i] <= occ[i] - 2'd1;
                    default: occ[i] <= occ[i];
                endcase
            end
            if (|drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // All status outputs come from registered state only.
    always_comb begin
        vbus.gates_ready = '0;
        vbus.q_valid     = '0;
        vbus.q_vals      = '0;
        for (int i = 0; i < nParallel; i++) begin
            vbus.gates_ready[i] = (occ[i] != 2'd2);
            vbus.q_valid[i]     = (occ[i] != 2'd0);
            vbus.q_vals[i]      = mem[i][rd_ptr[i]];
        end
    end

    assign vbus.count     = cnt;
    assign vbus.all_empty = ~|occ;
    assign vbus.overflow  = ovf;

endmodule

// File: tb/tb_prover_compute_v_gatesink.sv
// Directed bench for the V gate sink. dut_a is 4 lanes with an 8-bit count, and dut_b is 1 lane with a 3-bit count.
// Latency: inputs are driven and outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench acts as both the bank and the consumer.
module tb_prover_compute_v_gatesink;
    logic clk;
    logic rstb;
    logic restart_a;
    logic restart_b;

    int checks = 0;
    int errors = 0;

    prover_compute_v_gatesink_if #(.nParallel(4), .F_NBITS(16), .nCntBits(8)) bus_a ();
    prover_compute_v_gatesink_if #(.nParallel(1), .F_NBITS(16), .nCntBits(3)) bus_b ();

    prover_compute_v_gatesink #(.nParBits(2), .nCntBits(8), .F_NBITS(16)) dut_a (
        .clk     (clk),
        .rstb    (rstb),
        .restart (restart_a),
        .vbus    (bus_a)
    );

    prover_compute_v_gatesink #(.nParBits(0), .nCntBits(3), .F_NBITS(16)) dut_b (
        .clk     (clk),
        .rstb    (rstb),
        .restart (restart_b),
        .vbus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word 0 sits in the low bits.
    function automatic logic [63:0] quad(input int w0, input int w1, input int w2, input int w3);
        return {w3[15:0], w2[15:0], w1[15:0], w0[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_a_pulse();
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
    endtask

    initial begin
        rstb          = 1'b0;
        restart_a     = 1'b0;
        restart_b     = 1'b0;
        bus_a.in_vals = '0;
        bus_a.gates_en = '0;
        bus_a.q_ack   = '0;
        bus_b.in_vals = '0;
        bus_b.gates_en = '0;
        bus_b.q_ack   = '0;
        #12;

        // Reset state
        chk("rst_ready",  64'(bus_a.gates_ready), 64'hf);
        chk("rst_valid",  64'(bus_a.q_valid), 64'h0);
        chk("rst_vals",   64'(bus_a.q_vals), 64'h0);
        chk("rst_count",  64'(bus_a.count), 64'h0);
        chk("rst_empty",  64'(bus_a.all_empty), 64'h1);
        chk("rst_ovf",    64'(bus_a.overflow), 64'h0);
        chk("rst_b_ready", 64'(bus_b.gates_ready), 64'h1);
        rstb = 1'b1;
        tick();

        // 1. Basic transfer on lane 0
        bus_a.gates_en   = 4'b0001;
        bus_a.in_vals[0] = quad(1, 2, 3, 4);
        tick();
        bus_a.gates_en = '0;
        chk("t1_valid", 64'(bus_a.q_valid[0]), 64'h1);
        chk("t1_vals",  64'(bus_a.q_vals[0]), quad(1, 2, 3, 4));
        chk("t1_count", 64'(bus_a.count[0]), 64'd1);
        chk("t1_ready", 64'(bus_a.gates_ready[0]), 64'h1);
        chk("t1_empty", 64'(bus_a.all_empty), 64'h0);

        // 2. Fill and overflow
        restart_a_pulse();
        chk("t2_empty", 64'(bus_a.all_empty), 64'h1);
        bus_a.gates_en   = 4'b0001;
        bus_a.in_vals[0] = quad(1, 2, 3, 4);
        tick();
        bus_a.in_vals[0] = quad(5, 6, 7, 8);
        tick();
        chk("t2_ready_full", 64'(bus_a.gates_ready[0]), 64'h0);
        chk("t2_count2",     64'(bus_a.count[0]), 64'd2);
        chk("t2_ovf_pre",    64'(bus_a.overflow), 64'h0);
        bus_a.in_vals[0] = quad(9, 10, 11, 12);
        tick();
        bus_a.gates_en = '0;
        chk("t2_ovf",   64'(bus_a.overflow), 64'h1);
        chk("t2_count", 64'(bus_a.count[0]), 64'd2);
        chk("t2_head",  64'(bus_a.q_vals[0]), quad(1, 2, 3, 4));
        bus_a.q_ack = 4'b0001;
        tick();
        chk("t2_head2", 64'(bus_a.q_vals[0]), quad(5, 6, 7, 8));
        tick();
        bus_a.q_ack = '0;
        chk("t2_drained", 64'(bus_a.q_valid[0]), 64'h0);

        // 3. Simultaneous accept and pop at occ=1
        restart_a_pulse();
        chk("t3_ovf_clr", 64'(bus_a.overflow), 64'h0);
        bus_a.gates_en   = 4'b0001;
        bus_a.in_vals[0] = quad(1, 2, 3, 4);
        tick();
        bus_a.in_vals[0] = quad(5, 6, 7, 8);
        bus_a.q_ack      = 4'b0001;
        tick();
        bus_a.gates_en = '0;
        chk("t3_head",  64'(bus_a.q_vals[0]), quad(5, 6, 7, 8));
        chk("t3_valid", 64'(bus_a.q_valid[0]), 64'h1);
        chk("t3_ready", 64'(bus_a.gates_ready[0]), 64'h1);
        chk("t3_count", 64'(bus_a.count[0]), 64'd2);
        tick();
        bus_a.q_ack = '0;
        chk("t3_occ1_empty", 64'(bus_a.all_empty), 64'h1);

        // 4. Streaming 100 quads with ack held high
        restart_a_pulse();
        bus_a.q_ack = 4'b0001;
        for (int k = 0; k < 100; k++) begin
            bus_a.gates_en   = 4'b0001;
            bus_a.in_vals[0] = quad(k, k + 1, k + 2, k + 3);
            tick();
            chk("t4_head",  64'(bus_a.q_vals[0]), quad(k, k + 1, k + 2, k + 3));
            chk("t4_ready", 64'(bus_a.gates_ready[0]), 64'h1);
        end
        bus_a.gates_en = '0;
        tick();
        bus_a.q_ack = '0;
        chk("t4_count", 64'(bus_a.count[0]), 64'd100);
        chk("t4_valid", 64'(bus_a.q_valid[0]), 64'h0);
        chk("t4_ovf",   64'(bus_a.overflow), 64'h0);

        // 6. Lane independence: lane 3 is filled and never acked
        restart_a_pulse();
        bus_a.q_ack = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            bus_a.gates_en = (k < 2) ? 4'b1111 : 4'b0111;
            for (int l = 0; l < 3; l++) begin
                bus_a.in_vals[l] = quad(l * 1000 + k, l * 1000 + k + 1, l * 1000 + k + 2, l * 1000 + k + 3);
            end
            bus_a.in_vals[3] = quad(500 + k, 501 + k, 502 + k, 503 + k);
            tick();
            chk("t6_lane0", 64'(bus_a.q_vals[0]), quad(k, k + 1, k + 2, k + 3));
            chk("t6_lane2", 64'(bus_a.q_vals[2]), quad(2000 + k, 2001 + k, 2002 + k, 2003 + k));
        end
        bus_a.gates_en = '0;
        chk("t6_ready",  64'(bus_a.gates_ready), 64'h7);
        chk("t6_empty",  64'(bus_a.all_empty), 64'h0);
        chk("t6_cnt3",   64'(bus_a.count[3]), 64'd2);
        chk("t6_cnt1",   64'(bus_a.count[1]), 64'd10);
        chk("t6_head3",  64'(bus_a.q_vals[3]), quad(500, 501, 502, 503));
        chk("t6_valid",  64'(bus_a.q_valid), 64'hf);
        tick();
        bus_a.q_ack = '0;
        chk("t6_valid2", 64'(bus_a.q_valid), 64'h8);
        chk("t6_ready2", 64'(bus_a.gates_ready), 64'h7);
        chk("t6_ovf",    64'(bus_a.overflow), 64'h0);

        // 5. Saturation and restart collision on the 3-bit counter instance
        bus_b.q_ack = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            bus_b.gates_en   = 1'b1;
            bus_b.in_vals[0] = quad(k, k, k, k);
            tick();
            chk("t5_count", 64'(bus_b.count[0]), 64'((k < 7) ? k : 7));
        end
        bus_b.q_ack = 1'b0;
        bus_b.in_vals[0] = quad(20, 21, 22, 23);
        tick();
        tick();
        chk("t5_ovf",   64'(bus_b.overflow), 64'h1);
        chk("t5_ready", 64'(bus_b.gates_ready), 64'h0);
        chk("t5_sat",   64'(bus_b.count[0]), 64'd7);
        chk("t5_head",  64'(bus_b.q_vals[0]), quad(9, 9, 9, 9));
        restart_b = 1'b1;
        tick();
        restart_b      = 1'b0;
        bus_b.gates_en = 1'b0;
        chk("t5_rs_count", 64'(bus_b.count[0]), 64'd0);
        chk("t5_rs_empty", 64'(bus_b.all_empty), 64'h1);
        chk("t5_rs_ovf",   64'(bus_b.overflow), 64'h0);
        chk("t5_rs_valid", 64'(bus_b.q_valid), 64'h0);
        tick();
        chk("t5_rs_ignored", 64'(bus_b.q_valid), 64'h0);

        // Asynchronous reset mid-transfer
        bus_a.gates_en   = 4'b0001;
        bus_a.in_vals[0] = quad(7, 7, 7, 7);
        tick();
        chk("ar_pre_valid", 64'(bus_a.q_valid[0]), 64'h1);
        #3;
        rstb = 1'b0;
        #1;
        chk("ar_valid", 64'(bus_a.q_valid), 64'h0);
        chk("ar_ready", 64'(bus_a.gates_ready), 64'hf);
        chk("ar_empty", 64'(bus_a.all_empty), 64'h1);
        chk("ar_vals",  64'(bus_a.q_vals[0]), 64'h0);
        chk("ar_count", 64'(bus_a.count[0]), 64'h0);
        bus_a.gates_en = '0;
        tick();
        rstb = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prover_compute_v_gatesink.md
# prover_compute_v_gatesink

Receiving end of the V-value handshake driven by the prover's V shift-register bank. For each parallel lane it accepts 4-word quads of field elements on a one-cycle `gates_en` strobe, holds them in a 2-entry FIFO, and presents them to the downstream gate-evaluation logic with a valid/ack handshake. Per lane, `gates_ready` back-pressures the bank. The block also counts the quads each lane accepts and flags any strobe that arrives while that lane's FIFO is full.

## Interface
Parameters:
- `nParBits`, default 0: log2 of the lane count; must match the V bank.
- `nCntBits`, default 8: width of each per-lane accepted-quad counter.
- `nParallel`, default `1 << nParBits`: derived; do not override. Any mismatch instantiates an error module at elaboration.

Ports:
- `clk`, in, 1: clock.
- `rstb`, in, 1: reset, asynchronous, active-low.
- `restart`, in, 1: synchronous clear of FIFOs, counters and error flag.
- `in_vals`, in, `F_NBITS` x [nParallel][4]: quad from each bank lane.
- `gates_en`, in, nParallel: per-lane strobe; the quad is valid in this cycle.
- `gates_ready`, out, nParallel: lane can accept a quad.
- `q_vals`, out, `F_NBITS` x [nParallel][4]: head quad of each lane FIFO.
- `q_valid`, out, nParallel: head quad present.
- `q_ack`, in, nParallel: consumer pops the head.
- `count`, out, nCntBits x [nParallel]: quads accepted since reset or restart.
- `all_empty`, out, 1: every lane FIFO is empty.
- `overflow`, out, 1: sticky; a strobe was dropped on some lane.

## Operation
- Lanes are fully independent. Each lane has a 2-entry quad storage, head/tail pointers and an occupancy register `occ` in {0,1,2}.
- Accept: `gates_en[i]` with `occ[i] < 2`.
  - Writes all four words of `in_vals[i]` to the tail entry.
  - Increments `count[i]`; the counter saturates at `2^nCntBits - 1` and does not wrap.
- Drop: `gates_en[i]` with `occ[i] == 2`.
  - Data is discarded and `count[i]` is unchanged.
  - `overflow` sets the next cycle.
  - There is no bypass: a simultaneous `q_ack[i]` does not make room for the strobe.
- Pop: `q_ack[i]` with `q_valid[i]` advances the head. `q_ack` while `q_valid` is low is ignored.
- Simultaneous accept and pop at `occ == 1`: `occ` stays 1 and the new quad becomes the head on the next cycle.
- Output derivation:
  - `gates_ready[i] = (occ[i] != 2)`.
  - `q_valid[i] = (occ[i] != 0)`.
  - `all_empty` is high when all `occ` are 0.
  - All three are derived from registered state only, with no combinational path from any input.
- `q_vals[i]` always shows the head entry's storage. When `occ` is 0 it holds the last value in that entry, which is 0 after reset.
- `restart`:
  - Sets all `occ` and pointers to 0, all counters to 0 and `overflow` to 0.
  - A `gates_en` or `q_ack` in the same cycle is ignored.
  - Storage contents are not cleared.

## Timing
- Reset values:
  - `gates_ready` = all 1.
  - `q_valid` = 0.
  - `q_vals` = 0.
  - `count` = 0.
  - `all_empty` = 1.
  - `overflow` = 0.
- Latency:
  - From an accepted `gates_en` at edge N, `q_valid` is high after edge N and data is visible at cycle N+1.
  - `gates_ready` drops in cycle N+1 if that write filled the FIFO.
- Pop at edge N: `q_valid`, `q_vals` and `gates_ready` reflect the new state at cycle N+1.
- Throughput: one quad per cycle per lane, sustained, when the consumer acks every cycle.
- The bank samples `gates_ready` in the same cycle it asserts `gates_en`. The 2-entry depth absorbs one strobe issued against stale ready information.
- Asynchronous reset mid-transfer discards any in-flight strobe; outputs take their reset values immediately.

## Test plan
1. Basic transfer, nParBits=0:
   - Stimulus: reset, then `gates_en` with quad {1,2,3,4} and `q_ack` held low.
   - Required: `q_valid`=1 next cycle, `q_vals`={1,2,3,4}, `count`=1, `gates_ready`=1.
2. Fill and overflow:
   - Stimulus: three consecutive strobes {1..4}, {5..8}, {9..12} with no ack.
   - Required: `gates_ready`=0 after the second strobe and `count`=2. The third strobe is dropped, `overflow`=1, and the head is still {1..4}.
3. Simultaneous accept and pop:
   - Stimulus: at `occ`=1, strobe {5..8} and `q_ack` in the same cycle.
   - Required: `occ` stays 1, head becomes {5..8}, `count` increments.
4. Streaming:
   - Stimulus: 100 back-to-back strobes carrying values k..k+3, with `q_ack` tied high.
   - Required: every quad is received in order, `gates_ready` never falls, final `count`=100.
5. Restart collision and saturation:
   - Stimulus: nCntBits=3, 9 accepted quads, then `restart` asserted together with a strobe.
   - Required: `count` saturates at 7 before the restart. After it, `count`=0, `all_empty`=1, `overflow`=0, and the strobe is ignored.
6. Lane independence, nParBits=2:
   - Stimulus: lane 3 is filled and never acked; lanes 0–2 stream with acks.
   - Required: only `gates_ready[3]`=0, other lanes are unaffected, `all_empty`=0.
